// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared FSM states, channel codes, default widths and round-robin helper for adc_sample_sequencer
package adc_seq_pkg;
  localparam int DATA_W_DEF = 10;
  localparam int DIV_W_DEF = 16;
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_TICK = 2'd1,
    S_CONVERT   = 2'd2,
    S_PUSH      = 2'd3
  } state_e;
  localparam logic [1:0] CH_NONE = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;
  function automatic logic [1:0] next_ch(input logic [1:0] mask, input logic [1:0] last);
    return (last == CH1) ? (mask[1] ? CH2 : mask[0] ? CH1 : CH_NONE)
                         : (mask[0] ? CH1 : mask[1] ? CH2 : CH_NONE);
  endfunction
endpackage

// File: rtl/adc_seq_tick_gen.sv
// adc_seq_tick_gen: sample-rate timer (clk_i, rst_n_i, enable_i, divider_i in; tick_o out), tick every divider_i+1 cycles, divider reloaded at each wrap
module adc_seq_tick_gen
  import adc_seq_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] divider_i,
  output logic             tick_o
);
  logic [DIV_W-1:0] cnt_q, div_q;
  logic wrap;
  assign wrap = cnt_q == div_q;
  assign tick_o = enable_i & wrap;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      div_q <= '0;
    end else if (!enable_i || wrap) begin
      cnt_q <= '0;
      div_q <= divider_i;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: tick-timed round-robin ADC sequencer (driver start/done handshake in, valid/ready tagged sample out, sticky overrun_o, busy_o); ADC_SEQ_TIMEOUT_EN adds timeout_o
module adc_sample_sequencer
  import adc_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W = DIV_W_DEF
`ifdef ADC_SEQ_TIMEOUT_EN
  ,parameter int TIMEOUT_CYC = 256
`endif
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic [1:0]        ch_mask_i,
  input  logic [DIV_W-1:0]  divider_i,
  output logic              start_sample_o,
  output logic [1:0]        channel_num_o,
  input  logic              data_ready_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              sample_valid_o,
  input  logic              sample_ready_i,
  output logic [DATA_W-1:0] sample_data_o,
  output logic [1:0]        sample_ch_o,
  output logic              overrun_o,
  output logic              busy_o
`ifdef ADC_SEQ_TIMEOUT_EN
  ,output logic             timeout_o
`endif
);
  state_e state_q, state_d;
  logic [1:0] last_q, last_d, ch_q, ch_d, tag_q, tag_d, sel;
  logic start_q, start_d, valid_q, valid_d, ovr_q, ovr_d, dr_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic tick, done_edge, tmo_hit;
  adc_seq_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .enable_i(enable_i),
    .divider_i(divider_i),
    .tick_o(tick)
  );
  assign sel = next_ch(ch_mask_i, last_q);
  assign done_edge = data_ready_i & ~dr_q;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    ch_d = ch_q;
    tag_d = tag_q;
    start_d = start_q;
    valid_d = valid_q;
    data_d = data_q;
    ovr_d = ovr_q | (tick & (state_q == S_CONVERT || state_q == S_PUSH));
    if (!enable_i) begin
      state_d = S_IDLE;
      start_d = 1'b0;
      ch_d = CH_NONE;
      valid_d = 1'b0;
      ovr_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT_TICK;
        S_WAIT_TICK: if (tick && sel != CH_NONE) begin
          state_d = S_CONVERT;
          start_d = 1'b1;
          ch_d = sel;
          last_d = sel;
        end
        S_CONVERT: if (done_edge) begin
          state_d = S_PUSH;
          start_d = 1'b0;
          ch_d = CH_NONE;
          valid_d = 1'b1;
          data_d = data_i;
          tag_d = ch_q;
        end else if (tmo_hit) begin
          state_d = S_WAIT_TICK;
          start_d = 1'b0;
          ch_d = CH_NONE;
        end
        S_PUSH: if (sample_ready_i) begin
          state_d = S_WAIT_TICK;
          valid_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      last_q <= CH2;
      ch_q <= CH_NONE;
      tag_q <= CH_NONE;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
      data_q <= '0;
      dr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      ch_q <= ch_d;
      tag_q <= tag_d;
      start_q <= start_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
      data_q <= data_d;
      dr_q <= data_ready_i;
    end
  end
`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tcnt_q;
  logic tmo_q;
  assign tmo_hit = state_q == S_CONVERT && tcnt_q == TLAST;
  assign timeout_o = tmo_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tcnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tcnt_q <= (enable_i && state_q == S_CONVERT && !tmo_hit) ? tcnt_q + 1'b1 : '0;
      tmo_q <= enable_i & (tmo_q | (tmo_hit & ~done_edge));
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif
  assign start_sample_o = start_q;
  assign channel_num_o = ch_q;
  assign sample_valid_o = valid_q;
  assign sample_data_o = data_q;
  assign sample_ch_o = tag_q;
  assign overrun_o = ovr_q;
  assign busy_o = state_q != S_IDLE;
endmodule

// File: doc/adc_sample_sequencer.md
Name: adc_sample_sequencer

Overview:
Sequences the serial ADC driver for the scope front end. A programmable sample-rate timer triggers conversions, and channels 1 and 2 are chosen round-robin under an enable mask. The block runs the start/done handshake with the driver and pushes each tagged 10-bit sample into the capture path over a valid/ready interface. It sits between the control registers and the ADC driver, upstream of the capture buffer.

Parameters:
DATA_W, 10, ADC sample width
DIV_W, 16, sample-rate divider width
TIMEOUT_CYC, 256, clk_i cycles allowed per conversion (optional feature only)

Ports:
clk_i  in  1  system clock; all inputs synchronous to it
rst_n_i  in  1  asynchronous active-low reset
enable_i  in  1  run sampling; low = stop and abort
ch_mask_i  in  2  bit0 = channel 1 enabled, bit1 = channel 2 enabled
divider_i  in  DIV_W  sample period = divider_i+1 cycles
start_sample_o  out  1  request to ADC driver
channel_num_o  out  2  channel to driver: 1 or 2 (0 when idle)
data_ready_i  in  1  driver done level
data_i  in  DATA_W  driver sample
sample_valid_o  out  1  sample slot full
sample_ready_i  in  1  downstream accepts
sample_data_o  out  DATA_W  sample
sample_ch_o  out  2  channel tag of sample (1 or 2)
overrun_o  out  1  sticky: tick missed
busy_o  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0; FSM in IDLE; tick counter 0; round-robin pointer selects channel 1 first.
- Tick counter: runs only while enable_i=1. Counts 0..divider_i, then wraps to 0 and pulses tick for 1 cycle. divider_i=0 gives a tick every cycle. divider_i is re-read at every wrap.
- Channel select: on each tick, pick the next set bit of ch_mask_i after the last-served channel. Mask 01 -> always ch1. Mask 10 -> always ch2. Mask 11 -> alternate 1,2,1,... Mask 00 -> tick ignored; no overrun flagged.
- FSM states: IDLE, WAIT_TICK, CONVERT, PUSH.
  - IDLE -> WAIT_TICK when enable_i=1.
  - WAIT_TICK -> CONVERT on a tick with a valid channel. Next cycle: channel_num_o is set and start_sample_o=1.
  - CONVERT holds start_sample_o and channel_num_o stable until a rising edge of data_ready_i. The edge is detected as data_ready_i=1 with the registered previous value =0. A level that is already high on entry is not a done.
  - On the edge: data_i and the channel are captured into the slot, start_sample_o drops next cycle, and the FSM goes to PUSH.
  - PUSH: sample_valid_o=1. sample_data_o and sample_ch_o are stable while valid=1 and ready=0. On the valid and ready handshake the slot clears and the FSM returns to WAIT_TICK, so a sample completes in one cycle when ready is already high.
- Overrun: a tick arriving in CONVERT or PUSH sets overrun_o, and that tick is dropped (no queueing). overrun_o clears only when enable_i=0 or on reset.
- enable_i=0 in any state:
  - Next cycle: FSM to IDLE, start_sample_o=0, channel_num_o=0.
  - The tick counter resets and any pending slot is discarded (valid drops).
  - The round-robin pointer is kept.
- An enable_i fall and a data_ready_i edge in the same cycle: the abort wins and no sample is produced.
- Mask change mid-conversion: the current conversion completes; the new mask applies at the next tick.

Optional Feature:
ADC_SEQ_TIMEOUT_EN
- Defined: adds output timeout_o (1 bit, sticky, cleared like overrun_o) and a cycle counter running in CONVERT. When TIMEOUT_CYC cycles pass without a done edge: set timeout_o, drop start_sample_o, discard the conversion, advance the round-robin pointer, and go to WAIT_TICK.
- Undefined: no port and no counter; CONVERT waits indefinitely.

Decomposition:
- Package adc_seq_pkg holds:
  - FSM state encoding constants;
  - channel codes CH1=2'd1 and CH2=2'd2, plus CH_NONE=0;
  - default DATA_W and DIV_W.
- One sub-module, adc_seq_tick_gen: the divider counter with enable and wrap, producing the tick pulse.
- Channel select, handshake and output slot stay in the top level.

Test Plan:
- Mask 01, divider 99, ready=1, driver model done 30 cycles after start -> one sample per 100 cycles, sample_ch_o=1, data matches model, overrun_o=0.
- Mask 11, divider 49 -> sample_ch_o sequence 1,2,1,2; channel_num_o matches during each CONVERT.
- Divider 9, conversion 30 cycles -> overrun_o=1 after the second tick; samples still produced every third-or-fourth tick; overrun_o clears when enable_i toggles low.
- Hold sample_ready_i=0 for 20 cycles in PUSH -> valid stays 1 and data/tag stay constant; the tick in that window sets overrun_o; release -> one handshake, return to WAIT_TICK.
- Drop enable_i mid-CONVERT -> start_sample_o=0 and channel_num_o=0 next cycle, no sample output. Assert rst_n_i=0 asynchronously mid-PUSH -> all outputs 0 immediately.
- With ADC_SEQ_TIMEOUT_EN and TIMEOUT_CYC=256, the driver never signals done -> start_sample_o drops 256 cycles after entry, timeout_o=1, next tick selects the next channel.
